// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg: shared definitions for the serial_tx frame transmitter.
//   - tx_state_e : transmitter FSM states (PARITY is only reachable when
//                  SERIAL_TX_PARITY_EN is defined)
//   - LINE_IDLE / START_BIT / STOP_BIT : line levels
//   - cnt_w()    : counter width helper, $clog2(n) with a floor of 1
package serial_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } tx_state_e;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_tx_bit_timer.sv
// bit_timer: counts CLKS_PER_BIT cycles per line bit and pulses tick on the
// last cycle of each bit (the wrap).
//   clock  in  rising-edge clock
//   resetn in  asynchronous active-low reset
//   clear  in  hold the counter at 0 (no tick while asserted)
//   tick   out high in the final cycle of a bit period
module bit_timer
    import serial_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = cnt_w(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;

    // With CLKS_PER_BIT == 1 the counter is pinned at 0 and tick is simply !clear.
    assign tick = !clear && (r_cnt == LAST);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)             r_cnt <= '0;
        else if (clear || tick)  r_cnt <= '0;
        else                     r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/serial_tx.sv
// serial_tx: parallel-in, serial-out frame transmitter.
// Frame: start(0), DATA_W data bits LSB first, [even parity], stop(1); each
// bit held CLKS_PER_BIT cycles. All line changes launch on the rising edge.
// Optional feature macro: SERIAL_TX_PARITY_EN (adds a parity bit that is the
// XOR of the data bits).
//   clock     in  rising-edge clock
//   resetn    in  asynchronous active-low reset
//   tx_data   in  DATA_W word, captured on accept
//   tx_valid  in  requester has a word
//   tx_ready  out high in IDLE only; accept = tx_valid && tx_ready
//   tx_serial out registered serial line, idles high
//   tx_busy   out high while a frame is on the line
//   tx_done   out one-cycle pulse in the first IDLE cycle after the stop bit
module serial_tx
    import serial_tx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_serial,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int            BW       = cnt_w(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    tx_state_e         r_state;
    logic [DATA_W-1:0] r_shreg;
    logic [BW-1:0]     r_bitcnt;
    logic              r_serial;
    logic              r_done;
`ifdef SERIAL_TX_PARITY_EN
    logic              r_parity;
`endif

    logic              w_tick;
    logic              w_accept;
    logic [DATA_W-1:0] w_shnext;

    assign tx_ready  = (r_state == S_IDLE);
    assign tx_busy   = !tx_ready;
    assign tx_serial = r_serial;
    assign tx_done   = r_done;
    assign w_accept  = tx_valid && tx_ready;
    assign w_shnext  = r_shreg >> 1;

    // Timer is held clear in IDLE so every frame starts on a fresh bit period.
    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clock (clock),
        .resetn(resetn),
        .clear (tx_ready),
        .tick  (w_tick)
    );

    // The line register is loaded with the level of the *next* bit on each
    // transition, so tx_serial never comes from combinational decode.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_serial <= LINE_IDLE;
            r_done   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_state  <= S_START;
                    r_shreg  <= tx_data;
                    r_bitcnt <= '0;
                    r_serial <= START_BIT;
`ifdef SERIAL_TX_PARITY_EN
                    r_parity <= ^tx_data;
`endif
                end
                S_START: if (w_tick) begin
                    r_state  <= S_DATA;
                    r_serial <= r_shreg[0];
                end
                S_DATA: if (w_tick) begin
                    r_shreg <= w_shnext;
                    if (r_bitcnt == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
                        r_state  <= S_PARITY;
                        r_serial <= r_parity;
`else
                        r_state  <= S_STOP;
                        r_serial <= STOP_BIT;
`endif
                    end else begin
                        r_bitcnt <= r_bitcnt + 1'b1;
                        r_serial <= w_shnext[0];
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                S_PARITY: if (w_tick) begin
                    r_state  <= S_STOP;
                    r_serial <= STOP_BIT;
                end
`endif
                S_STOP: if (w_tick) begin
                    r_state  <= S_IDLE;
                    r_serial <= LINE_IDLE;
                    r_done   <= 1'b1;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_serial <= LINE_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: two serial_tx instances (CLKS_PER_BIT = 4 and 1) share one
// stimulus stream. Each has a cycle-offset reference model: once a word is
// accepted, the expected line value k cycles later is frame bit (k-1)/CPB,
// busy covers k = 1..F and done is high at k = F+1.
module tb_serial_tx;

    localparam int DW = 8;
`ifdef SERIAL_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int F0 = (DW + 2 + PB) * 4;

    logic          clk  = 1'b0;
    logic          rstn = 1'b1;
    logic          v    = 1'b0;
    logic [DW-1:0] d    = '0;
    logic          ser [2];
    logic          rdy [2];
    logic          bsy [2];
    logic          dn  [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame bits in line order: start, data LSB first, [parity], stop.
    function automatic logic [DW+2:0] mk_frame(input logic [DW-1:0] x);
        logic [DW+2:0] b;
        b = '1;
        b[0] = 1'b0;
        for (int i = 0; i < DW; i++) b[i+1] = x[i];
        if (PB == 1) b[DW+1] = ^x;
        return b;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int CPB = (g == 0) ? 4 : 1;
        localparam int F   = (DW + 2 + PB) * CPB;

        serial_tx #(
            .DATA_W      (DW),
            .CLKS_PER_BIT(CPB)
        ) u_dut (
            .clock    (clk),
            .resetn   (rstn),
            .tx_data  (d),
            .tx_valid (v),
            .tx_ready (rdy[g]),
            .tx_serial(ser[g]),
            .tx_busy  (bsy[g]),
            .tx_done  (dn[g])
        );

        bit            live = 1'b0;
        int            k    = 0;
        logic [DW+2:0] bits = '1;

        always @(posedge clk or negedge rstn) begin
            bit busy_prev;
            if (!rstn) begin
                live = 1'b0;
            end else begin
                busy_prev = live && (k >= 1) && (k <= F);
                if (live) k = k + 1;
                if (v && !busy_prev) begin
                    live = 1'b1;
                    k    = 1;
                    bits = mk_frame(d);
                end
            end
        end

        always @(negedge clk) begin
            bit e_busy;
            e_busy = live && (k >= 1) && (k <= F);
            chk($sformatf("line%0d", g),  {31'd0, ser[g]}, {31'd0, e_busy ? bits[(k-1)/CPB] : 1'b1});
            chk($sformatf("busy%0d", g),  {31'd0, bsy[g]}, {31'd0, e_busy});
            chk($sformatf("ready%0d", g), {31'd0, rdy[g]}, {31'd0, !e_busy});
            chk($sformatf("done%0d", g),  {31'd0, dn[g]},  {31'd0, live && (k == F + 1)});
        end
    end

    // Present one word for a single cycle, then park tx_data on junk.
    task automatic send(input logic [DW-1:0] x, input int wait_cyc);
        v = 1'b1;
        d = x;
        @(negedge clk);
        v = 1'b0;
        d = DW'($urandom);
        repeat (wait_cyc) @(negedge clk);
    endtask

    initial begin
        // Reset with tx_valid high: nothing may be accepted.
        #1 rstn = 1'b0;
        v = 1'b1;
        d = 8'h77;
        repeat (4) @(negedge clk);
        v    = 1'b0;
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Directed frame.
        send(8'hA5, F0 + 3);

        // Back-to-back with tx_valid held: 01 then FF.
        v = 1'b1;
        d = 8'h01;
        @(negedge clk);
        d = 8'hFF;
        repeat (F0 + 1) @(negedge clk);
        v = 1'b0;
        repeat (F0 + 3) @(negedge clk);

        // Randomized frames with random idle gaps.
        for (int i = 0; i < 8; i++)
            send(DW'($urandom), F0 + 1 + int'($urandom_range(0, 3)));

        // Requests while busy are ignored.
        send(8'h96, 12);
        v = 1'b1;
        d = 8'h3C;
        repeat (2) @(negedge clk);
        v = 1'b0;
        repeat (F0) @(negedge clk);

        // Reset during data bit 3 (line low there for 8'hF0).
        send(8'hF0, 17);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_line", {31'd0, ser[0]}, 32'd1);
        chk("async_rst_done", {31'd0, dn[0]},  32'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        send(8'h5A, F0 + 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
